// File: rtl/sprite_engine_pkg.sv
// Sprite engine shared definitions.
// Holds the table geometry, the packed attribute word layout, the FSM state
// encoding and the sprite ROM address builder used by the engine.
package sprite_pkg;

   localparam int unsigned NUM_SPRITES  = 32;
   localparam int unsigned SPR_SIZE     = 16;
   localparam int unsigned MAX_PER_LINE = 8;
   localparam int unsigned LINE_W       = 640;

   // Attribute word: [31] enable, [30] flip_h, [29:25] frame, [24:15] x,
   // [14:6] y, [5:0] reserved.
   typedef struct packed {
      logic       enable;
      logic       flip_h;
      logic [4:0] frame;
      logic [9:0] x;
      logic [8:0] y;
      logic [5:0] rsvd;
   } sprite_attr_t;

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      DRAW,
      DRAIN,
      DONE
   } sprite_state_t;

   // ROM address {frame, row, column}; a mirrored sprite reads columns
   // right-to-left (15 - col is the bitwise inverse of a 4-bit col).
   function automatic logic [12:0] rom_address(input logic [4:0] frame,
                                               input logic [3:0] row,
                                               input logic [3:0] col,
                                               input logic       flip_h);
      return {frame, row, (flip_h ? ~col : col)};
   endfunction

endpackage

// File: rtl/sprite_engine_if.sv
// Sprite engine bus bundle.
// slave : engine side (control, attribute write port, ROM port, linebuffer
//         write port, done flag).
// master: driver side (scanline controller / CPU / ROM / linebuffer).
interface sprite_engine_if;

   logic        sprite_start;
   logic [9:0]  draw_line;
   logic        attr_we;
   logic [4:0]  attr_addr;
   logic [31:0] attr_wdata;
   logic [12:0] rom_addr;
   logic [15:0] rom_q;
   logic [9:0]  addr_pixel_draw;
   logic [15:0] data_pixel_draw;
   logic        wren_pixel_draw;
   logic        sprite_done;

   modport slave (
      input  sprite_start, draw_line, attr_we, attr_addr, attr_wdata, rom_q,
      output rom_addr, addr_pixel_draw, data_pixel_draw, wren_pixel_draw,
             sprite_done
   );

   modport master (
      output sprite_start, draw_line, attr_we, attr_addr, attr_wdata, rom_q,
      input  rom_addr, addr_pixel_draw, data_pixel_draw, wren_pixel_draw,
             sprite_done
   );

endinterface

// File: rtl/sprite_engine_attr_ram.sv
// sprite_attr_ram: 32 x 32-bit sprite attribute table.
// Ports: clk, reset (async, active-low, clears every entry), we/waddr/wdata
// write port, raddr -> rdata combinational read port. A read of the entry
// being written in the same cycle returns the old contents.
module sprite_attr_ram
   import sprite_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         we,
   input  logic [4:0]   waddr,
   input  logic [31:0]  wdata,
   input  logic [4:0]   raddr,
   output sprite_attr_t rdata
);

   sprite_attr_t mem [NUM_SPRITES];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= sprite_attr_t'(wdata);
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sprite_engine.sv
// sprite_engine: renders up to MAX_PER_LINE 16x16 sprites into one scanline.
// Ports: clk, reset (async, active-low), bus (slave modport of
// sprite_engine_if): sprite_start/draw_line control, attr_* table write
// port, rom_addr/rom_q sprite ROM port, *_pixel_draw linebuffer write port,
// sprite_done level flag.
// A line costs 33 cycles of scanning plus 17 cycles per drawn sprite
// (16 ROM issues + one drain cycle for the last pixel's write).
module sprite_engine
   import sprite_pkg::*;
(
   input logic             clk,
   input logic             reset,
   sprite_engine_if.slave  bus
);

   sprite_state_t state, state_next;

   logic [5:0]   idx;        // bit 5 set means all 32 entries scanned
   logic [3:0]   hit_cnt;
   logic [3:0]   col;
   logic [9:0]   line_q;
   logic         cur_flip;
   logic [4:0]   cur_frame;
   logic [9:0]   cur_x;
   logic [3:0]   cur_row;
   logic         wr_valid;
   logic [10:0]  wr_addr;

   sprite_attr_t attr;
   logic [9:0]   y_ext;
   logic [9:0]   dy;
   logic         hit;
   logic         can_draw;
   logic         start_ok;
   logic         unused_bits;

   sprite_attr_ram u_attr (
      .clk   (clk),
      .reset (reset),
      .we    (bus.attr_we),
      .waddr (bus.attr_addr),
      .wdata (bus.attr_wdata),
      .raddr (idx[4:0]),
      .rdata (attr)
   );

   // Hit test at 10 bits: line >= y rules out wrap before the <16 check.
   assign y_ext    = {1'b0, attr.y};
   assign dy       = line_q - y_ext;
   assign hit      = attr.enable && (line_q >= y_ext) && (dy < 10'd16);
   assign can_draw = hit && (hit_cnt < 4'(MAX_PER_LINE));
   assign start_ok = bus.sprite_start && ((state == IDLE) || (state == DONE));
   assign unused_bits = ^{attr.rsvd, SPR_SIZE[0]};

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE, DONE: if (start_ok) state_next = SCAN;
         SCAN: begin
            if (idx[5])        state_next = DONE;
            else if (can_draw) state_next = DRAW;
         end
         DRAW:  if (col == 4'd15) state_next = DRAIN;
         DRAIN: state_next = SCAN;
         default: state_next = IDLE;
      endcase
   end

   // Counters, latched sprite and write-stage pipeline
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx       <= '0;
         hit_cnt   <= '0;
         col       <= '0;
         line_q    <= '0;
         cur_flip  <= 1'b0;
         cur_frame <= '0;
         cur_x     <= '0;
         cur_row   <= '0;
         wr_valid  <= 1'b0;
         wr_addr   <= '0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (start_ok) begin
                  line_q  <= bus.draw_line;
                  idx     <= '0;
                  hit_cnt <= '0;
               end
            end
            SCAN: begin
               if (!idx[5]) begin
                  if (can_draw) begin
                     // Latch the entry so attribute writes during DRAW
                     // cannot corrupt a sprite already being drawn.
                     cur_flip  <= attr.flip_h;
                     cur_frame <= attr.frame;
                     cur_x     <= attr.x;
                     cur_row   <= dy[3:0];
                     col       <= '0;
                  end else begin
                     idx <= idx + 6'd1;
                  end
               end
            end
            DRAW: col <= col + 4'd1;
            DRAIN: begin
               hit_cnt <= hit_cnt + 4'd1;
               idx     <= idx + 6'd1;
            end
            default: ;
         endcase
         wr_valid <= (state == DRAW);
         wr_addr  <= {1'b0, cur_x} + {7'b0, col};
      end
   end

   // Outputs; everything is gated by state or wr_valid so reset forces 0.
   always_comb begin
      bus.rom_addr        = '0;
      bus.addr_pixel_draw = '0;
      bus.data_pixel_draw = '0;
      bus.wren_pixel_draw = 1'b0;
      bus.sprite_done     = (state == DONE);
      if (state == DRAW) begin
         bus.rom_addr = rom_address(cur_frame, cur_row, col, cur_flip);
      end
      if (wr_valid) begin
         bus.addr_pixel_draw = wr_addr[9:0];
         bus.data_pixel_draw = bus.rom_q;
         bus.wren_pixel_draw = !bus.rom_q[15] && (wr_addr < 11'(LINE_W));
      end
   end

endmodule

// File: tb/tb_sprite_engine.sv
module tb_sprite_engine;

   logic clk;
   logic reset;
   sprite_engine_if sif ();

   sprite_engine dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sif.slave)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   int passed = 0;
   int total  = 0;

   // ROM model: 0 = opaque {3'b0, addr}, 1 = column field only,
   // 2 = like 0 but transparent when column field is odd.
   int rom_mode = 0;
   always @(posedge clk) begin
      case (rom_mode)
         1:       sif.rom_q <= {12'b0, sif.rom_addr[3:0]};
         2:       sif.rom_q <= {sif.rom_addr[0], 2'b0, sif.rom_addr};
         default: sif.rom_q <= {3'b0, sif.rom_addr};
      endcase
   end

   // Linebuffer model and write monitor
   logic [15:0] lb [1024];
   int          wr_cnt  = 0;
   int          oob_cnt = 0;
   logic [12:0] last_ra = '0;
   always @(negedge clk) begin
      if (sif.rom_addr != 13'd0) last_ra = sif.rom_addr;
      if (sif.wren_pixel_draw) begin
         wr_cnt++;
         if (sif.addr_pixel_draw >= 10'd640) oob_cnt++;
         lb[sif.addr_pixel_draw] = sif.data_pixel_draw;
      end
   end

   function automatic logic [31:0] mk_attr(input logic en, input logic flip,
                                           input logic [4:0] frame,
                                           input logic [9:0] x,
                                           input logic [8:0] y);
      return {en, flip, frame, x, y, 6'b0};
   endfunction

   function automatic logic [15:0] px(input logic [4:0] frame,
                                      input logic [3:0] row,
                                      input logic [3:0] c);
      return {3'b0, frame, row, c};
   endfunction

   task automatic wr_attr(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      sif.attr_we    = 1'b1;
      sif.attr_addr  = a;
      sif.attr_wdata = d;
      @(negedge clk);
      sif.attr_we    = 1'b0;
   endtask

   task automatic clear_attrs();
      for (int i = 0; i < 32; i++) wr_attr(5'(i), 32'd0);
   endtask

   task automatic clear_lb();
      for (int i = 0; i < 1024; i++) lb[i] = 16'hFFFF;
      wr_cnt  = 0;
      oob_cnt = 0;
   endtask

   // Start a line; n_done = edges after the start edge when done was seen.
   // A second start pulse is driven at edge poke+1 (poke <= 0 disables it).
   task automatic run_line(input logic [9:0] line, input int poke,
                           output int n_done);
      clear_lb();
      @(negedge clk);
      sif.draw_line    = line;
      sif.sprite_start = 1'b1;
      @(posedge clk);
      #1 sif.sprite_start = 1'b0;
      n_done = -1;
      for (int n = 1; n <= 2000; n++) begin
         @(posedge clk);
         #1;
         sif.sprite_start = (n == poke);
         if (sif.sprite_done) begin
            n_done = n;
            break;
         end
      end
      sif.sprite_start = 1'b0;
      total++;
      if (n_done < 0) $display("FAIL line_timeout: got no sprite_done, required done within 2000 cycles");
      else passed++;
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      sif.sprite_start = 1'b0;
      sif.draw_line    = '0;
      sif.attr_we      = 1'b0;
      sif.attr_addr    = '0;
      sif.attr_wdata   = '0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (sif.rom_addr !== 13'd0) $display("FAIL rst_rom_addr: got %0h required 0", sif.rom_addr); else passed++;
      total++; if (sif.wren_pixel_draw !== 1'b0) $display("FAIL rst_wren: got %0b required 0", sif.wren_pixel_draw); else passed++;
      total++; if (sif.addr_pixel_draw !== 10'd0) $display("FAIL rst_addr: got %0h required 0", sif.addr_pixel_draw); else passed++;
      total++; if (sif.data_pixel_draw !== 16'd0) $display("FAIL rst_data: got %0h required 0", sif.data_pixel_draw); else passed++;
      total++; if (sif.sprite_done !== 1'b0) $display("FAIL rst_done: got %0b required 0", sif.sprite_done); else passed++;
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_all_disabled();
      int n;
      rom_mode = 0;
      run_line(10'd100, 0, n);
      total++; if (n !== 33) $display("FAIL empty_done_time: got %0d required 33", n); else passed++;
      total++; if (wr_cnt !== 0) $display("FAIL empty_writes: got %0d required 0", wr_cnt); else passed++;
      repeat (3) @(negedge clk);
      total++; if (sif.sprite_done !== 1'b1) $display("FAIL done_level: got %0b required 1", sif.sprite_done); else passed++;
   endtask

   task automatic test_single();
      int n;
      int bad;
      rom_mode = 0;
      wr_attr(5'd0, mk_attr(1'b1, 1'b0, 5'd2, 10'd10, 9'd95));
      run_line(10'd100, 0, n);
      total++; if (n !== 50) $display("FAIL single_done_time: got %0d required 50", n); else passed++;
      total++; if (wr_cnt !== 16) $display("FAIL single_writes: got %0d required 16", wr_cnt); else passed++;
      bad = 0;
      for (int c = 0; c < 16; c++) if (lb[10 + c] !== px(5'd2, 4'd5, 4'(c))) bad++;
      total++; if (bad !== 0) $display("FAIL single_pixels: got %0d bad columns required 0", bad); else passed++;
      total++; if (lb[9] !== 16'hFFFF || lb[26] !== 16'hFFFF) $display("FAIL single_bounds: got %0h/%0h required ffff/ffff", lb[9], lb[26]); else passed++;
      total++; if (last_ra[7:4] !== 4'd5) $display("FAIL single_rom_row: got %0d required 5", last_ra[7:4]); else passed++;
   endtask

   task automatic test_flip();
      int n;
      rom_mode = 1;
      wr_attr(5'd0, mk_attr(1'b1, 1'b1, 5'd2, 10'd10, 9'd95));
      run_line(10'd100, 0, n);
      total++; if (n !== 50) $display("FAIL flip_done_time: got %0d required 50", n); else passed++;
      total++; if (lb[10] !== 16'd15) $display("FAIL flip_col10: got %0d required 15", lb[10]); else passed++;
      total++; if (lb[25] !== 16'd0) $display("FAIL flip_col25: got %0d required 0", lb[25]); else passed++;
      total++; if (lb[17] !== 16'd8) $display("FAIL flip_col17: got %0d required 8", lb[17]); else passed++;
   endtask

   task automatic test_right_edge();
      int n;
      rom_mode = 0;
      wr_attr(5'd0, mk_attr(1'b1, 1'b0, 5'd4, 10'd630, 9'd95));
      run_line(10'd100, 0, n);
      total++; if (wr_cnt !== 10) $display("FAIL edge_writes: got %0d required 10", wr_cnt); else passed++;
      total++; if (oob_cnt !== 0) $display("FAIL edge_oob: got %0d required 0", oob_cnt); else passed++;
      total++; if (lb[639] !== px(5'd4, 4'd5, 4'd9)) $display("FAIL edge_col639: got %0h required %0h", lb[639], px(5'd4, 4'd5, 4'd9)); else passed++;
      rom_mode = 2;
      run_line(10'd100, 0, n);
      total++; if (wr_cnt !== 5) $display("FAIL transp_writes: got %0d required 5", wr_cnt); else passed++;
      total++; if (lb[631] !== 16'hFFFF) $display("FAIL transp_col631: got %0h required ffff", lb[631]); else passed++;
      total++; if (lb[632] !== px(5'd4, 4'd5, 4'd2)) $display("FAIL transp_col632: got %0h required %0h", lb[632], px(5'd4, 4'd5, 4'd2)); else passed++;
   endtask

   task automatic test_priority();
      int n;
      rom_mode = 0;
      clear_attrs();
      wr_attr(5'd0, mk_attr(1'b1, 1'b0, 5'd1, 10'd300, 9'd95));
      wr_attr(5'd1, mk_attr(1'b1, 1'b0, 5'd3, 10'd308, 9'd95));
      wr_attr(5'd2, mk_attr(1'b1, 1'b0, 5'd6, 10'd400, 9'd101));
      run_line(10'd100, 0, n);
      total++; if (n !== 67) $display("FAIL prio_done_time: got %0d required 67", n); else passed++;
      total++; if (lb[310] !== px(5'd3, 4'd5, 4'd2)) $display("FAIL prio_overlap: got %0h required %0h", lb[310], px(5'd3, 4'd5, 4'd2)); else passed++;
      total++; if (lb[305] !== px(5'd1, 4'd5, 4'd5)) $display("FAIL prio_low: got %0h required %0h", lb[305], px(5'd1, 4'd5, 4'd5)); else passed++;
      total++; if (lb[400] !== 16'hFFFF) $display("FAIL prio_below_y: got %0h required ffff", lb[400]); else passed++;
   endtask

   task automatic test_max_per_line();
      int n;
      rom_mode = 0;
      for (int i = 0; i < 10; i++) wr_attr(5'(i), mk_attr(1'b1, 1'b0, 5'(i), 10'(i * 20), 9'd95));
      run_line(10'd100, 50, n);
      total++; if (n !== 169) $display("FAIL max_done_time: got %0d required 169", n); else passed++;
      total++; if (wr_cnt !== 128) $display("FAIL max_writes: got %0d required 128", wr_cnt); else passed++;
      total++; if (lb[140] !== px(5'd7, 4'd5, 4'd0)) $display("FAIL max_entry7: got %0h required %0h", lb[140], px(5'd7, 4'd5, 4'd0)); else passed++;
      total++; if (lb[160] !== 16'hFFFF) $display("FAIL max_entry8: got %0h required ffff", lb[160]); else passed++;
   endtask

   task automatic test_reset_mid_draw();
      int n;
      rom_mode = 0;
      clear_attrs();
      wr_attr(5'd0, mk_attr(1'b1, 1'b0, 5'd2, 10'd10, 9'd95));
      clear_lb();
      @(negedge clk);
      sif.draw_line    = 10'd100;
      sif.sprite_start = 1'b1;
      @(posedge clk);
      #1 sif.sprite_start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (sif.rom_addr === 13'd0) $display("FAIL mid_in_draw: got rom_addr 0 required nonzero"); else passed++;
      reset = 1'b0;
      #1;
      total++; if (sif.rom_addr !== 13'd0) $display("FAIL mid_rom_addr: got %0h required 0", sif.rom_addr); else passed++;
      total++; if (sif.wren_pixel_draw !== 1'b0 || sif.addr_pixel_draw !== 10'd0 || sif.data_pixel_draw !== 16'd0)
         $display("FAIL mid_pixel_port: got %0b/%0h/%0h required 0/0/0", sif.wren_pixel_draw, sif.addr_pixel_draw, sif.data_pixel_draw);
      else passed++;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      wr_cnt = 0;
      repeat (20) @(negedge clk);
      total++; if (wr_cnt !== 0) $display("FAIL mid_after_release: got %0d writes required 0", wr_cnt); else passed++;
      run_line(10'd100, 0, n);
      total++; if (wr_cnt !== 0) $display("FAIL mid_cleared_table: got %0d writes required 0", wr_cnt); else passed++;
      total++; if (n !== 33) $display("FAIL mid_done_time: got %0d required 33", n); else passed++;
   endtask

   initial begin
      test_reset();
      test_all_disabled();
      test_single();
      test_flip();
      test_right_edge();
      test_priority();
      test_max_per_line();
      test_reset_mid_draw();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
